bcd_uart_sender: RTL and testbench

- Upstream feeder for the UART transmitter: takes a binary value, converts it to decimal with a sequential double-dabble, and streams it as ASCII text bytes, most-significant digit first, followed by CR LF.
- Drives the transmitter's data-valid/byte inputs and consumes its active/done outputs.
- One byte handed over per transmitter frame.

---
 rtl/bcd_uart_sender_if.sv | 24 ++
 rtl/bcd_uart_sender.sv | 194 +++++++++++++++++++
 tb/tb_bcd_uart_sender.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_uart_sender_if.sv
// Handshake bundle between the BCD/ASCII sender, its requester and the UART transmitter.
// The sender uses the slave modport; the requester/transmitter side uses master.
interface bcd_uart_sender_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  i_Start;
    logic [DATA_WIDTH-1:0] i_Value;
    logic                  o_Busy;
    logic                  o_Done;
    logic                  o_Tx_DV;
    logic [7:0]            o_Tx_Byte;
    logic                  i_Tx_Active;
    logic                  i_Tx_Done;

    modport slave (
        input  i_Start, i_Value, i_Tx_Active, i_Tx_Done,
        output o_Busy, o_Done, o_Tx_DV, o_Tx_Byte
    );

    modport master (
        output i_Start, i_Value, i_Tx_Active, i_Tx_Done,
        input  o_Busy, o_Done, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/bcd_uart_sender.sv
// Converts a binary value to decimal (sequential double-dabble) and streams it as ASCII + CR LF
// to a UART transmitter. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_uart_sender #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_DIGITS = 5
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    bcd_uart_sender_if.slave  bus
);

    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS + 3);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] MaxVal = (64'd1 << DATA_WIDTH) - 64'd1;

    if (pow10(NUM_DIGITS) <= MaxVal) begin : g_digit_check
        $error("NUM_DIGITS too small to represent every DATA_WIDTH-bit value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [BcdW-1:0]       bcd_adj;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dv_q, dv_d;
    logic [7:0]            byte_q, byte_d;
    logic [3:0]            digit;
`ifdef LEADING_ZERO_BLANK_EN
    logic                  lead_q, lead_d;
`endif

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dv_d      = 1'b0;
        byte_d    = byte_q;
        digit     = bcd_q[BcdW-1 -: 4];
`ifdef LEADING_ZERO_BLANK_EN
        lead_d    = lead_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (bus.i_Start && !done_q) begin
                    bin_d     = bus.i_Value;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                    lead_d    = 1'b1;
`endif
                    state_d   = S_CONVERT;
                end
            end

            S_CONVERT: begin
                bcd_d     = {bcd_adj[BcdW-2:0], bin_q[DATA_WIDTH-1]};
                bin_d     = bin_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                idx_d = idx_q + 1'b1;
                if (idx_q < IdxW'(NUM_DIGITS)) begin
                    // Digits are consumed from the top nibble, so the BCD register shifts up.
                    bcd_d = bcd_q << 4;
`ifdef LEADING_ZERO_BLANK_EN
                    if (lead_q && digit == 4'd0 && idx_q != IdxW'(NUM_DIGITS - 1)) begin
                        state_d = S_LOAD;
                    end else begin
                        lead_d  = 1'b0;
                        byte_d  = {4'h3, digit};
                        state_d = S_ARM;
                    end
`else
                    byte_d  = {4'h3, digit};
                    state_d = S_ARM;
`endif
                end else if (idx_q == IdxW'(NUM_DIGITS)) begin
                    byte_d  = 8'h0D;
                    state_d = S_ARM;
                end else begin
                    byte_d  = 8'h0A;
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                if (!bus.i_Tx_Active && !bus.i_Tx_Done) begin
                    dv_d    = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.i_Tx_Done) begin
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (!bus.i_Tx_Done) begin
                    if (idx_q == IdxW'(NUM_DIGITS + 2)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dv_q      <= 1'b0;
            byte_q    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            lead_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dv_q      <= dv_d;
            byte_q    <= byte_d;
`ifdef LEADING_ZERO_BLANK_EN
            lead_q    <= lead_d;
`endif
        end
    end

    assign bus.o_Busy    = busy_q;
    assign bus.o_Done    = done_q;
    assign bus.o_Tx_DV   = dv_q;
    assign bus.o_Tx_Byte = byte_q;

endmodule

// File: tb/tb_bcd_uart_sender.sv
// Bench for bcd_uart_sender: behavioural UART transmitter (4 clocks/bit), line decoder,
// byte scoreboard and protocol monitor.
module tb_bcd_uart_sender;

    localparam int unsigned DW   = 16;
    localparam int unsigned CPB  = 4;
    localparam int unsigned BASE_LAT = DW + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_uart_sender_if #(.DATA_WIDTH(DW)) bus ();

    bcd_uart_sender #(
        .DATA_WIDTH (DW),
        .NUM_DIGITS (5)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    // Transmitter model: not reset by rst_n, so it finishes any in-flight frame.
    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    logic       tx_line   = 1'b1;
    logic [9:0] tx_frame  = '1;
    int         tx_cnt    = 0;
    int         tx_st     = 0;

    assign bus.i_Tx_Active = tx_active;
    assign bus.i_Tx_Done   = tx_done;

    always @(posedge clk) begin
        case (tx_st)
            0: if (bus.o_Tx_DV) begin
                tx_frame  <= {1'b1, bus.o_Tx_Byte, 1'b0};
                tx_cnt    <= 0;
                tx_active <= 1'b1;
                tx_st     <= 1;
            end
            1: begin
                tx_line <= tx_frame[tx_cnt / CPB];
                tx_cnt  <= tx_cnt + 1;
                if (tx_cnt == 10 * CPB - 1) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                    tx_st     <= 2;
                end
            end
            2: begin
                tx_line <= 1'b1;
                tx_st   <= 3;
            end
            default: begin
                tx_done <= 1'b0;
                tx_st   <= 0;
            end
        endcase
    end

    typedef struct {
        logic [15:0] value;
        string       pad;
        string       blank;
    } vec_t;

    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_q[$];
    int         discard = 0;
    int         dv_cnt  = 0;
    int         done_cnt = 0;
    int         frames  = 0;
    vec_t       vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic string sel(input string pad, input string blank);
`ifdef LEADING_ZERO_BLANK_EN
        return blank;
`else
        return pad;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic       prev_dv = 1'b0;
        logic       prev_done = 1'b0;
        logic       holding = 1'b0;
        logic [7:0] held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) holding = 1'b0;
            if (bus.o_Tx_DV) begin
                dv_cnt++;
                check("dv_tx_idle", {30'd0, tx_active, tx_done}, 0);
                check("dv_width", prev_dv, 0);
                held    = bus.o_Tx_Byte;
                holding = 1'b1;
            end else if (holding) begin
                if (tx_done) begin
                    check("byte_stable", bus.o_Tx_Byte, held);
                    holding = 1'b0;
                end else if (bus.o_Tx_Byte !== held) begin
                    check("byte_stable", bus.o_Tx_Byte, held);
                    holding = 1'b0;
                end
            end
            if (bus.o_Done) begin
                done_cnt++;
                check("done_width", prev_done, 0);
            end
            prev_dv   = bus.o_Tx_DV;
            prev_done = bus.o_Done;
        end
    endtask

    // Samples the serial line mid-bit, relative to the first low seen.
    task automatic decoder();
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                b = '0;
                for (int o = 1; o <= 38; o++) begin
                    @(negedge clk);
                    if (o >= 6 && o <= 34 && (o % 4) == 2) b[o/4 - 1] = tx_line;
                end
                check("stop_bit", tx_line, 1);
                if (discard > 0) begin
                    discard--;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%02h required=none", b);
                end else begin
                    check("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] value, input string text, input bit idle_tx,
                        input bit poke, input bit hold_start);
        int lat;
        bit got_dv;
        bit got_done;
        bit busy_ok;
        for (int i = 0; i < text.len(); i++) exp_q.push_back(text[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        bus.i_Value = value;
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        bus.i_Value = 16'($urandom);
        lat = 0; got_dv = 0; got_done = 0; busy_ok = 1;
        for (int c = 1; c <= 3000; c++) begin
            tick();
            if (!got_dv && bus.o_Tx_DV) begin
                got_dv = 1;
                lat    = c;
            end
            if (poke && c == 60) begin
                bus.i_Start = 1'b1;
                bus.i_Value = 16'd7;
            end
            if (poke && c == 61) bus.i_Start = 1'b0;
            if (bus.o_Done) begin
                got_done = 1;
                break;
            end
            if (!bus.o_Busy) busy_ok = 0;
        end
        check("done_seen", got_done, 1);
        check("busy_high", busy_ok, 1);
        if (idle_tx) check("first_dv_latency", lat, BASE_LAT + 5 - text.len());
        else         check("dv_withheld", lat > int'(BASE_LAT), 1);
        check("bytes_left", exp_q.size(), 0);
        if (hold_start) begin
            bus.i_Start = 1'b1;
            bus.i_Value = 16'd3;
        end
        tick();
        bus.i_Start = 1'b0;
        check("done_one_cycle", bus.o_Done, 0);
        check("busy_after_done", bus.o_Busy, 0);
        if (hold_start) begin
            repeat (2) tick();
            check("start_on_done_ignored", bus.o_Busy, 0);
        end
        frames++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit reached;
        vecs[0] = '{16'd42,    "00042", "42"};
        vecs[1] = '{16'd65535, "65535", "65535"};
        vecs[2] = '{16'd0,     "00000", "0"};
        vecs[3] = '{16'd10000, "10000", "10000"};
        vecs[4] = '{16'd1,     "00001", "1"};
        vecs[5] = '{16'd909,   "00909", "909"};
        vecs[6] = '{16'd59999, "59999", "59999"};

        rst_n       = 1'b0;
        bus.i_Start = 1'b0;
        bus.i_Value = '0;
        fork
            monitor();
            decoder();
        join_none
        repeat (3) tick();
        check("rst_busy", bus.o_Busy, 0);
        check("rst_done", bus.o_Done, 0);
        check("rst_dv", bus.o_Tx_DV, 0);
        check("rst_byte", bus.o_Tx_Byte, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) send(vecs[i].value, sel(vecs[i].pad, vecs[i].blank), 1, 0, 0);

        send(16'd123, sel("00123", "123"), 1, 1, 0);
        send(16'd5, sel("00005", "5"), 1, 0, 1);

        // Reset mid-frame while the third character is on the line.
        begin
            string t;
            t = sel("00123", "123");
            for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
        end
        base = dv_cnt;
        bus.i_Value = 16'd123;
        bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (dv_cnt >= base + 3) begin
                reached = 1;
                break;
            end
        end
        check("third_dv_seen", reached, 1);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_busy", bus.o_Busy, 0);
        check("midreset_dv", bus.o_Tx_DV, 0);
        check("midreset_done", bus.o_Done, 0);
        check("midreset_byte", bus.o_Tx_Byte, 0);
        exp_q.delete();
        discard = 1;
        send(16'd9, sel("00009", "9"), 0, 0, 0);

        repeat (5) tick();
        check("done_pulses", done_cnt, frames);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
